piso_shift_tx: RTL and testbench

Parallel-in, serial-out transmitter that feeds the bidirectional shift register's serial inputs. It accepts a W-bit word over a valid/ready handshake, together with a per-word shift direction. It then emits the word one bit per enabled clock, in the order that makes the receiving shift register hold exactly that word after W shifts in the same mode. The block sits upstream of the receiver: `sout` drives `dr` or `dl`, and `mode_out` drives `mode`.

---
 rtl/shift_pkg.sv | 14 +
 rtl/piso_shift_tx_if.sv | 27 ++
 rtl/piso_shift_tx.sv | 81 ++++++++
 tb/tb_piso_shift_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the bidirectional shift register and its serial transmitter.
package shift_pkg;

   // Shift direction encoding, common with the receiving shift register.
   localparam logic MODE_LEFT  = 1'b0;
   localparam logic MODE_RIGHT = 1'b1;

   // Transmitter FSM states.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_t;

endpackage

// File: rtl/piso_shift_tx_if.sv
// Word-load handshake between a producer and the serial transmitter.
interface piso_shift_tx_if #(
   parameter int unsigned W = 4
) ();

   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] load_data;
   logic         load_mode;

   // Producer side: offers words, observes acceptance.
   modport master (
      output load_valid,
      output load_data,
      output load_mode,
      input  load_ready
   );

   // Transmitter side: accepts words.
   modport slave (
      input  load_valid,
      input  load_data,
      input  load_mode,
      output load_ready
   );

endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter. Emits a W-bit word one bit per enabled clock
// in the order that leaves the downstream shift register holding the same word.
module piso_shift_tx
   import shift_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic            clk,
   input  logic            clr,
   piso_shift_tx_if.slave  load,
   input  logic            shift_en,
   output logic            sout,
   output logic            sout_valid,
   output logic            sout_last,
   output logic            mode_out,
   output logic            busy
);

   localparam int unsigned CW = $clog2(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   localparam logic [0:0] ST_IDLE  = 1'(IDLE);
   localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

   logic [0:0]    state_q;
   logic [W-1:0]  sr_q;
   logic [CW-1:0] cnt_q;
   logic          mode_q;

   logic in_shift;
   logic at_last;
   logic advance;
   logic accept;

   // Handshake and progress decode; ready depends only on state, counter, shift_en and clr.
   always_comb begin
      in_shift        = (state_q == ST_SHIFT);
      at_last         = in_shift && (cnt_q == CNT_LAST);
      advance         = in_shift && shift_en;
      load.load_ready = !clr && (!in_shift || (at_last && shift_en));
      accept          = load.load_valid && load.load_ready;
   end

   // State, shift register, bit counter and captured direction.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else if (accept) begin
         // Also covers the back-to-back case on the previous word's last edge.
         state_q <= ST_SHIFT;
         sr_q    <= load.load_data;
         mode_q  <= load.load_mode;
         cnt_q   <= '0;
      end else if (advance) begin
         if (at_last) begin
            // Counter holds at its final value rather than wrapping.
            state_q <= ST_IDLE;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (mode_q == MODE_RIGHT) begin
            sr_q <= {1'b0, sr_q[W-1:1]};
         end else begin
            sr_q <= {sr_q[W-2:0], 1'b0};
         end
      end
   end

   // Outputs; everything reads 0 while clr is asserted.
   always_comb begin
      sout_valid = !clr && in_shift;
      busy       = !clr && in_shift;
      sout_last  = !clr && at_last;
      mode_out   = !clr && mode_q;
      sout       = !clr && in_shift && ((mode_q == MODE_RIGHT) ? sr_q[0] : sr_q[W-1]);
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx with a scoreboard of expected serial bits
// and a behavioural receiving shift register for loopback checks.
module tb_piso_shift_tx;
   import shift_pkg::*;

   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic clr;
   logic shift_en;
   logic sout;
   logic sout_valid;
   logic sout_last;
   logic mode_out;
   logic busy;

   piso_shift_tx_if #(.W(W)) lif ();

   piso_shift_tx #(.W(W)) dut (
      .clk        (clk),
      .clr        (clr),
      .load       (lif),
      .shift_en   (shift_en),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_last  (sout_last),
      .mode_out   (mode_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic b;
      logic last;
      logic mode;
   } exp_bit_t;

   exp_bit_t     sb[$];
   int           n_checks = 0;
   int           n_errors = 0;
   int           consumed = 0;
   logic         last_mode = 1'b0;
   logic [W-1:0] rx = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_word(input logic [W-1:0] d, input logic m);
      exp_bit_t e;
      for (int i = 0; i < W; i++) begin
         e.b    = (m == MODE_RIGHT) ? d[i] : d[W-1-i];
         e.last = (i == W - 1);
         e.mode = m;
         sb.push_back(e);
      end
   endtask

   // Offer a word and wait for acceptance; load_valid is left high for back-to-back use.
   task automatic offer(input logic [W-1:0] d, input logic m);
      bit done = 1'b0;
      lif.load_valid = 1'b1;
      lif.load_data  = d;
      lif.load_mode  = m;
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge clk);
         if (lif.load_ready === 1'b1) done = 1'b1;
         @(posedge clk);
         #1;
      end
      check_eq("accepted", 32'(done), 32'd1);
      if (done) push_word(d, m);
   endtask

   task automatic send(input logic [W-1:0] d, input logic m);
      offer(d, m);
      lif.load_valid = 1'b0;
   endtask

   task automatic wait_idle();
      while (sb.size() != 0) @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_consumed(input int n);
      while (consumed < n) @(posedge clk);
      #1;
   endtask

   // Monitor: compare outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      logic exp_ready;
      if (clr) begin
         check_eq("clr_ready", 32'(lif.load_ready), 32'd0);
         check_eq("clr_sout",  32'(sout),           32'd0);
         check_eq("clr_valid", 32'(sout_valid),     32'd0);
         check_eq("clr_last",  32'(sout_last),      32'd0);
         check_eq("clr_busy",  32'(busy),           32'd0);
         check_eq("clr_mode",  32'(mode_out),       32'd0);
      end else begin
         exp_ready = (sb.size() == 0) || (sb[0].last && shift_en);
         check_eq("ready", 32'(lif.load_ready), 32'(exp_ready));
         if (sb.size() != 0) begin
            check_eq("valid", 32'(sout_valid), 32'd1);
            check_eq("busy",  32'(busy),       32'd1);
            check_eq("sout",  32'(sout),       32'(sb[0].b));
            check_eq("last",  32'(sout_last),  32'(sb[0].last));
            check_eq("mode",  32'(mode_out),   32'(sb[0].mode));
            if (shift_en) begin
               if (mode_out == MODE_RIGHT) rx = {sout, rx[W-1:1]};
               else                        rx = {rx[W-2:0], sout};
               last_mode = sb[0].mode;
               void'(sb.pop_front());
               consumed++;
            end
         end else begin
            check_eq("idle_valid", 32'(sout_valid), 32'd0);
            check_eq("idle_busy",  32'(busy),       32'd0);
            check_eq("idle_sout",  32'(sout),       32'd0);
            check_eq("idle_last",  32'(sout_last),  32'd0);
            check_eq("idle_mode",  32'(mode_out),   32'(last_mode));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      clr            = 1'b1;
      shift_en       = 1'b1;
      lif.load_valid = 1'b0;
      lif.load_data  = '0;
      lif.load_mode  = 1'b0;
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      @(posedge clk);
      #1;

      // Right-mode and left-mode sends with loopback.
      send(4'b1011, MODE_RIGHT);
      wait_idle();
      check_eq("rx_right", 32'(rx), 32'(4'b1011));
      send(4'b1110, MODE_LEFT);
      wait_idle();
      check_eq("rx_left", 32'(rx), 32'(4'b1110));

      // Back-to-back: valid held across the word boundary.
      offer(4'b1011, MODE_RIGHT);
      offer(4'b0110, MODE_LEFT);
      lif.load_valid = 1'b0;
      wait_idle();
      check_eq("rx_b2b", 32'(rx), 32'(4'b0110));

      // Stall after bit 1 with a competing offer that must not be taken.
      base = consumed;
      send(4'b1001, MODE_RIGHT);
      wait_consumed(base + 2);
      shift_en       = 1'b0;
      lif.load_valid = 1'b1;
      lif.load_data  = 4'b0101;
      lif.load_mode  = MODE_LEFT;
      repeat (3) @(posedge clk);
      #1;
      lif.load_valid = 1'b0;
      shift_en       = 1'b1;
      wait_idle();
      check_eq("rx_stall", 32'(rx), 32'(4'b1001));
      check_eq("stall_total", 32'(consumed - base), 32'(W));

      // Reset mid-word: remaining bits are dropped.
      base = consumed;
      send(4'b0111, MODE_LEFT);
      wait_consumed(base + 2);
      clr = 1'b1;
      sb.delete();
      last_mode = 1'b0;
      @(posedge clk);
      #1 clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("abort_bits", 32'(consumed - base), 32'd2);
      send(4'b0110, MODE_RIGHT);
      wait_idle();
      check_eq("rx_after_clr", 32'(rx), 32'(4'b0110));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
